aes_inv_round_ctrl: RTL and testbench

//  Iterative AES inverse-cipher sequencer. Accepts one 128-bit ciphertext and computes one inverse round per clock.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_inv_round.sv | 47 ++++
 rtl/aes_inv_round_ctrl.sv | 112 +++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES inverse cipher.
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } fsm_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  localparam logic [7:0] GF_POLY = 8'h1B;

  localparam logic [3:0] IMC_E = 4'hE;
  localparam logic [3:0] IMC_B = 4'hB;
  localparam logic [3:0] IMC_D = 4'hD;
  localparam logic [3:0] IMC_9 = 4'h9;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse for a!=0 and yields 0 for a==0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] out
);

  logic [127:0] w_sub;
  logic [127:0] w_ark;
  logic [127:0] w_mix;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] o [4];
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      o[i] = gf_mul(a[i], {4'h0, IMC_E}) ^ gf_mul(a[(i+1)%4], {4'h0, IMC_B}) ^
             gf_mul(a[(i+2)%4], {4'h0, IMC_D}) ^ gf_mul(a[(i+3)%4], {4'h0, IMC_9});
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  // Byte (row r, column c) sits at index c*4+r; row r rotates right by r columns.
  always_comb begin
    w_sub = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sub[127-8*(c*4+r) -: 8] = inv_sbox(st[127-8*(((c-r+4)%4)*4+r) -: 8]);
      end
    end
  end

  assign w_ark = w_sub ^ rk;

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end
  end

  assign out = last ? w_ark : w_mix;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer, one inverse round per clock over a shared round datapath.
// Optional abort port enabled by defining AES_DEC_ABORT_EN.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef AES_DEC_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              data_in,
  output logic [$clog2(NR+1)-1:0]   rk_addr,
  input  logic [127:0]              rk_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              data_out,
  output logic                      busy
);

  localparam int RKW = $clog2(NR+1);

  fsm_t           r_fsm;
  fsm_t           w_fsm_nxt;
  logic [RKW-1:0] r_rnd;
  logic [127:0]   r_st;
  logic [127:0]   r_data_out;
  logic           r_out_valid;
  logic [127:0]   w_round;
  logic           w_last;
  logic           w_abort;

`ifdef AES_DEC_ABORT_EN
  assign w_abort = abort & (r_fsm != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_last = (r_fsm == S_FINAL);

  aes_inv_round u_round (
    .st   (r_st),
    .rk   (rk_data),
    .last (w_last),
    .out  (w_round)
  );

  always_comb begin
    w_fsm_nxt = r_fsm;
    rk_addr   = '0;
    case (r_fsm)
      S_IDLE: begin
        rk_addr = RKW'(NR);
        if (in_valid) w_fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        rk_addr = r_rnd;
        if (r_rnd == RKW'(1)) w_fsm_nxt = S_FINAL;
      end
      S_FINAL: w_fsm_nxt = S_DONE;
      S_DONE:  if (out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
    if (w_abort) w_fsm_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Abort drops the handshake and round count but leaves data_out as it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd       <= '0;
      r_st        <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_abort) begin
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_st  <= data_in ^ rk_data;
            r_rnd <= RKW'(NR-1);
          end
        end
        S_ROUND: begin
          r_st  <= w_round;
          r_rnd <= r_rnd - RKW'(1);
        end
        S_FINAL: begin
          r_data_out  <= w_round;
          r_out_valid <= 1'b1;
        end
        S_DONE:  if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl against a byte-level AES-128 inverse-cipher model.
module tb_aes_inv_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic         busy;
`ifdef AES_DEC_ABORT_EN
  logic         abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   isb  [256];
  logic [127:0] rks  [0:NR];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  aes_inv_round_ctrl #(.NR(NR)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_DEC_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    rk_data = '0;
    if (int'(rk_addr) <= NR) rk_data = rks[rk_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic build_sbox;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isb[s]  = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rks[NR][127-8*i -: 8];
    for (int rd = NR - 1; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[c*4+row] = isb[s[((c - row + 4) % 4)*4 + row]] ^ rks[rd][127-8*(c*4+row) -: 8];
      if (rd != 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) a[i] = t[c*4+i];
          for (int i = 0; i < 4; i++)
            t[c*4+i] = mul(a[i], 8'h0e) ^ mul(a[(i+1)%4], 8'h0b) ^
                       mul(a[(i+2)%4], 8'h0d) ^ mul(a[(i+3)%4], 8'h09);
        end
      end
      s = t;
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts ct from IDLE, waits for out_valid (bounded), then handshakes after ready_delay cycles.
  task automatic run_block(input logic [127:0] ct, input int ready_delay,
                           output logic [127:0] pt, output int lat, output bit to);
    in_valid = 1'b1;
    data_in  = ct;
    tick;
    in_valid = 1'b0;
    data_in  = rnd128();
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick;
      lat++;
    end
    to = !out_valid;
    pt = data_out;
    repeat (ready_delay) tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
    checks++; if (rk_addr !== 4'(NR)) begin errors++; $display("FAIL reset_rk_addr got %0d want %0d", rk_addr, NR); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_fips;
    bit rk_bad = 0;
    int first_bad = -1;
    expand_key(C1_KEY);
    in_valid = 1'b1;
    data_in  = C1_CT;
    if (rk_addr !== 4'(NR)) begin rk_bad = 1; first_bad = 0; end
    tick;
    in_valid = 1'b0;
    data_in  = '0;
    for (int k = 1; k <= NR; k++) begin
      if (rk_addr !== 4'(NR - k) || out_valid !== 1'b0) begin
        if (!rk_bad) first_bad = k;
        rk_bad = 1;
      end
      tick;
    end
    checks++; if (rk_bad) begin errors++; $display("FAIL fips_rk_seq got bad at cycle %0d want %0d..0", first_bad, NR); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fips_latency got out_valid=%b want 1 at cycle %0d", out_valid, NR+1); end
    checks++; if (data_out !== C1_PT) begin errors++; $display("FAIL fips_pt got %h want %h", data_out, C1_PT); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_idle got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_backpressure;
    logic [127:0] ct, pt;
    bit unstable = 0;
    int n = 0;
    ct = rnd128();
    in_valid = 1'b1;
    data_in  = ct;
    tick;
    in_valid = 1'b0;
    while (!out_valid && n < 50) begin tick; n++; end
    pt = data_out;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got out_valid=%b want 1", out_valid); end
    checks++; if (pt !== model_dec(ct)) begin errors++; $display("FAIL bp_pt got %h want %h", pt, model_dec(ct)); end
    for (int i = 0; i < 20; i++) begin
      tick;
      if (data_out !== pt || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) unstable = 1;
    end
    checks++; if (unstable) begin errors++; $display("FAIL bp_hold got changed outputs want stable DONE"); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_release got rdy=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] v0, v1;
    logic [127:0] got [2];
    int acc [2];
    int na = 0, no = 0;
    v0 = rnd128();
    v1 = rnd128();
    acc[0] = 0; acc[1] = 0; got[0] = '0; got[1] = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = v0;
    for (int i = 0; i < 3*(NR+2) + 4; i++) begin
      if (na == 1) data_in = v1;
      if (na >= 2) in_valid = 1'b0;
      if (out_valid && out_ready && no < 2) begin got[no] = data_out; no++; end
      if (in_valid && in_ready) begin acc[na] = i; na++; end
      tick;
    end
    out_ready = 1'b0;
    checks++; if (na != 2 || acc[1] - acc[0] != NR + 2)
      begin errors++; $display("FAIL b2b_spacing got %0d accepts gap %0d want 2 gap %0d", na, acc[1]-acc[0], NR+2); end
    checks++; if (got[0] !== model_dec(v0)) begin errors++; $display("FAIL b2b_pt0 got %h want %h", got[0], model_dec(v0)); end
    checks++; if (got[1] !== model_dec(v1)) begin errors++; $display("FAIL b2b_pt1 got %h want %h", got[1], model_dec(v1)); end
  endtask

  task automatic test_rst_mid;
    logic [127:0] pt;
    int lat, n = 0;
    bit to;
    in_valid = 1'b1;
    data_in  = rnd128();
    tick;
    in_valid = 1'b0;
    while (rk_addr !== 4'd5 && n < 30) begin tick; n++; end
    checks++; if (rk_addr !== 4'd5 || busy !== 1'b1) begin errors++; $display("FAIL rst_reach_rnd5 got rk_addr=%0d want 5", rk_addr); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 128'h0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_mid got ov=%b rdy=%b dout=%h want 0 1 0", out_valid, in_ready, data_out); end
    tick;
    rst = 1'b0;
    tick;
    expand_key(C1_KEY);
    run_block(C1_CT, 0, pt, lat, to);
    checks++; if (to || pt !== C1_PT) begin errors++; $display("FAIL rst_after_pt got %h want %h", pt, C1_PT); end
  endtask

  task automatic test_ignore_busy;
    logic [127:0] ct, exp_pt;
    bit rdy_bad = 0;
    int n = 0;
    expand_key(rnd128());
    ct = rnd128();
    exp_pt = model_dec(ct);
    in_valid = 1'b1;
    data_in  = ct;
    tick;
    while (!out_valid && n < 50) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = {128{1'b1}};
      if (in_ready !== 1'b0) rdy_bad = 1;
      tick;
      n++;
    end
    in_valid = 1'b0;
    checks++; if (rdy_bad) begin errors++; $display("FAIL ign_in_ready got 1 while busy want 0"); end
    checks++; if (out_valid !== 1'b1 || data_out !== exp_pt)
      begin errors++; $display("FAIL ign_pt got ov=%b %h want 1 %h", out_valid, data_out, exp_pt); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got busy=%b want 0", busy); end
  endtask

  task automatic test_random;
    logic [127:0] ct, pt;
    int lat;
    bit to;
    for (int it = 0; it < 6; it++) begin
      expand_key(rnd128());
      ct = rnd128();
      run_block(ct, $urandom_range(0, 3), pt, lat, to);
      checks++; if (to || lat != NR + 1) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", it, lat, NR+1); end
      checks++; if (pt !== model_dec(ct)) begin errors++; $display("FAIL rand_pt[%0d] got %h want %h", it, pt, model_dec(ct)); end
    end
  endtask

`ifdef AES_DEC_ABORT_EN
  task automatic test_abort;
    logic [127:0] ct, pt;
    bit seen = 0;
    int n = 0;
    in_valid = 1'b1;
    data_in  = rnd128();
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL abort_round got rdy=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    for (int i = 0; i < NR + 3; i++) begin if (out_valid) seen = 1; tick; end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_out got out_valid=1 want 0"); end
    ct = rnd128();
    in_valid = 1'b1;
    data_in  = ct;
    tick;
    in_valid = 1'b0;
    while (!out_valid && n < 50) begin tick; n++; end
    pt = data_out;
    abort = 1'b1;
    out_ready = 1'b1;
    tick;
    abort = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== pt || pt !== model_dec(ct))
      begin errors++; $display("FAIL abort_done got ov=%b rdy=%b dout=%h want 0 1 %h", out_valid, in_ready, data_out, model_dec(ct)); end
  endtask
`endif

  initial begin
    build_sbox();
    expand_key(C1_KEY);
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_rst_mid();
    test_ignore_busy();
    test_random();
`ifdef AES_DEC_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
